// File: rtl/match_controller_pkg.sv
// Shared types for the match controller slice.
//   phase_t      : bout phase encoding, also driven on phase_out
//   WIN_*        : winner_out codes
//   data_t       : generic byte-wide payload used across the game datapath
//   location_t   : screen coordinate pair used by the renderer side
//   sat_dec      : health decrement that sticks at zero
package match_controller_pkg;

  typedef enum logic [2:0] {
    PH_IDLE      = 3'd0,
    PH_COUNTDOWN = 3'd1,
    PH_FIGHT     = 3'd2,
    PH_FREEZE    = 3'd3,
    PH_GAME_OVER = 3'd4
  } phase_t;

  localparam logic [1:0] WIN_NONE     = 2'd0;
  localparam logic [1:0] WIN_PLAYER   = 2'd1;
  localparam logic [1:0] WIN_OPPONENT = 2'd2;
  localparam logic [1:0] WIN_DRAW     = 2'd3;

  typedef logic [7:0] data_t;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
  } location_t;

  function automatic logic [2:0] sat_dec(input logic [2:0] h);
    return (h == 3'd0) ? 3'd0 : h - 3'd1;
  endfunction

endpackage

// File: rtl/match_controller_frame_timer.sv
// frame_timer: 8-bit frame-tick counter shared by COUNTDOWN and FREEZE.
//   clk_pixel_in : clock
//   rst_in       : synchronous active-high reset
//   clear        : force count back to 0 (wins over tick)
//   tick         : qualified frame tick, advances the count
//   limit        : terminal count (1..255), may change with the phase
//   done         : combinational, high on the tick that reaches limit;
//                  the counter wraps to 0 on that same tick
module frame_timer (
  input  logic       clk_pixel_in,
  input  logic       rst_in,
  input  logic       clear,
  input  logic       tick,
  input  logic [7:0] limit,
  output logic       done
);

  logic [7:0] count;

  assign done = tick && (count == limit - 8'd1);

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in || clear) count <= 8'd0;
    else if (done)       count <= 8'd0;
    else if (tick)       count <= count + 8'd1;
  end

endmodule

// File: rtl/match_controller.sv
// match_controller: bout sequencing for a two-fencer game.
//   clk_pixel_in        : pixel clock, rising edge
//   rst_in              : synchronous active-high reset
//   start_in            : pulse, starts a bout from IDLE or GAME_OVER
//   frame_tick_in       : pulse per video frame, the only timebase
//   result_valid_in     : qualifies player/opponent_scored_in
//   player_scored_in    : local fencer landed a touch
//   opponent_scored_in  : remote fencer landed a touch
//   fight_enable_out    : high only while in FIGHT
//   phase_out           : current phase_t
//   countdown_out       : 3/2/1 in COUNTDOWN, else 0
//   player_health_out   : local health
//   opponent_health_out : remote health
//   touch_out           : one-cycle pulse per accepted touch
//   winner_out          : WIN_* code
module match_controller
  import match_controller_pkg::*;
#(
  parameter int START_HEALTH  = 3,
  parameter int SEC_FRAMES    = 60,
  parameter int FREEZE_FRAMES = 90
) (
  input  logic       clk_pixel_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic       frame_tick_in,
  input  logic       result_valid_in,
  input  logic       player_scored_in,
  input  logic       opponent_scored_in,
  output logic       fight_enable_out,
  output logic [2:0] phase_out,
  output logic [1:0] countdown_out,
  output logic [2:0] player_health_out,
  output logic [2:0] opponent_health_out,
  output logic       touch_out,
  output logic [1:0] winner_out
);

  localparam logic [2:0] HEALTH0 = 3'(START_HEALTH);

  phase_t     phase_q, phase_d;
  logic [1:0] cd_q, cd_d;
  logic [2:0] ph_q, ph_d, oh_q, oh_d;
  logic [1:0] win_q, win_d;
  logic       touch_q, touch_d;
  logic       fe_q;

  logic       tmr_clear, tmr_tick, tmr_done;
  logic [7:0] tmr_limit;
  logic       touch_evt;

  frame_timer u_timer (
    .clk_pixel_in (clk_pixel_in),
    .rst_in       (rst_in),
    .clear        (tmr_clear),
    .tick         (tmr_tick),
    .limit        (tmr_limit),
    .done         (tmr_done)
  );

  // Ticks only matter while timing; this also discards a tick that lands
  // on a touch, since touches are only taken in FIGHT.
  assign tmr_tick  = frame_tick_in &&
                     (phase_q == PH_COUNTDOWN || phase_q == PH_FREEZE);
  assign tmr_limit = (phase_q == PH_FREEZE) ? 8'(FREEZE_FRAMES) : 8'(SEC_FRAMES);
  assign touch_evt = result_valid_in && (player_scored_in || opponent_scored_in);

  always_comb begin
    phase_d   = phase_q;
    cd_d      = cd_q;
    ph_d      = ph_q;
    oh_d      = oh_q;
    win_d     = win_q;
    touch_d   = 1'b0;
    tmr_clear = 1'b0;
    case (phase_q)
      PH_IDLE, PH_GAME_OVER: begin
        if (start_in) begin
          ph_d      = HEALTH0;
          oh_d      = HEALTH0;
          win_d     = WIN_NONE;
          cd_d      = 2'd3;
          tmr_clear = 1'b1;
          phase_d   = PH_COUNTDOWN;
        end
      end
      PH_COUNTDOWN: begin
        if (tmr_done) begin
          if (cd_q == 2'd1) begin
            cd_d    = 2'd0;
            phase_d = PH_FIGHT;
          end else begin
            cd_d = cd_q - 2'd1;
          end
        end
      end
      PH_FIGHT: begin
        if (touch_evt) begin
          touch_d   = 1'b1;
          tmr_clear = 1'b1;
          if (player_scored_in)   oh_d = sat_dec(oh_q);
          if (opponent_scored_in) ph_d = sat_dec(ph_q);
          phase_d = PH_GAME_OVER;
          if      (ph_d == 3'd0 && oh_d == 3'd0) win_d = WIN_DRAW;
          else if (oh_d == 3'd0)                 win_d = WIN_PLAYER;
          else if (ph_d == 3'd0)                 win_d = WIN_OPPONENT;
          else                                   phase_d = PH_FREEZE;
        end
      end
      PH_FREEZE: begin
        if (tmr_done) begin
          cd_d    = 2'd3;
          phase_d = PH_COUNTDOWN;
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      phase_q <= PH_IDLE;
      cd_q    <= 2'd0;
      ph_q    <= HEALTH0;
      oh_q    <= HEALTH0;
      win_q   <= WIN_NONE;
      touch_q <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cd_q    <= cd_d;
      ph_q    <= ph_d;
      oh_q    <= oh_d;
      win_q   <= win_d;
      touch_q <= touch_d;
      // Decoded from the next phase so it drops with the health update.
      fe_q    <= (phase_d == PH_FIGHT);
    end
  end

  assign fight_enable_out    = fe_q;
  assign phase_out           = phase_q;
  assign countdown_out       = cd_q;
  assign player_health_out   = ph_q;
  assign opponent_health_out = oh_q;
  assign touch_out           = touch_q;
  assign winner_out          = win_q;

endmodule

// File: tb/tb_match_controller.sv
module tb_match_controller;
  localparam int SH = 3, SF = 60, FF = 90;
  localparam int P_IDLE = 0, P_CD = 1, P_FIGHT = 2, P_FRZ = 3, P_GO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, start = 1'b0, tick = 1'b0, rv = 1'b0, ps = 1'b0, os = 1'b0;
  logic       fe, touch;
  logic [2:0] phase, ph, oh;
  logic [1:0] cd, win;

  match_controller #(.START_HEALTH(SH), .SEC_FRAMES(SF), .FREEZE_FRAMES(FF)) dut (
    .clk_pixel_in(clk), .rst_in(rst), .start_in(start), .frame_tick_in(tick),
    .result_valid_in(rv), .player_scored_in(ps), .opponent_scored_in(os),
    .fight_enable_out(fe), .phase_out(phase), .countdown_out(cd),
    .player_health_out(ph), .opponent_health_out(oh), .touch_out(touch),
    .winner_out(win));

  int checks = 0, failures = 0;

  // Reference model: plain bout rules on integers.
  int m_phase = P_IDLE, m_cd = 0, m_ph = SH, m_oh = SH, m_win = 0;
  int m_touch = 0, m_cnt = 0;

  function automatic logic [14:0] exp_vec();
    return {1'(m_phase == P_FIGHT), 3'(m_phase), 2'(m_cd), 3'(m_ph), 3'(m_oh),
            1'(m_touch), 2'(m_win)};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {fe, phase, cd, ph, oh, touch, win};
  endfunction

  task automatic model(input bit s, t, v, p, o, r);
    m_touch = 0;
    if (r) begin
      m_phase = P_IDLE; m_cd = 0; m_ph = SH; m_oh = SH; m_win = 0; m_cnt = 0;
      return;
    end
    case (m_phase)
      P_IDLE, P_GO:
        if (s) begin
          m_phase = P_CD; m_cd = 3; m_ph = SH; m_oh = SH; m_win = 0; m_cnt = 0;
        end
      P_CD:
        if (t) begin
          m_cnt++;
          if (m_cnt == SF) begin
            m_cnt = 0;
            m_cd--;
            if (m_cd == 0) m_phase = P_FIGHT;
          end
        end
      P_FIGHT:
        if (v && (p || o)) begin
          m_touch = 1; m_cnt = 0;
          if (p && m_oh > 0) m_oh--;
          if (o && m_ph > 0) m_ph--;
          if (m_ph == 0 && m_oh == 0) begin m_win = 3; m_phase = P_GO; end
          else if (m_oh == 0)        begin m_win = 1; m_phase = P_GO; end
          else if (m_ph == 0)        begin m_win = 2; m_phase = P_GO; end
          else m_phase = P_FRZ;
        end
      P_FRZ:
        if (t) begin
          m_cnt++;
          if (m_cnt == FF) begin m_cnt = 0; m_phase = P_CD; m_cd = 3; end
        end
      default: ;
    endcase
  endtask

  // One clock: drive inputs, clock, advance model, settle past the edge.
  task automatic step(input bit s, t, v, p, o, r);
    start = s; tick = t; rv = v; ps = p; os = o; rst = r;
    @(posedge clk);
    model(s, t, v, p, o, r);
    #1;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_vec got=%h exp=%h", dut_vec(), exp_vec());
    end
    checks++;
    if (phase !== 3'd0 || ph !== 3'd3 || oh !== 3'd3 || cd !== 2'd0 || fe !== 1'b0) begin
      failures++; $display("FAIL reset_state ph=%0d hp=%0d/%0d cd=%0d fe=%0b", phase, ph, oh, cd, fe);
    end
  endtask

  task automatic test_countdown();
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (phase !== 3'd1 || cd !== 2'd3) begin
      failures++; $display("FAIL start phase=%0d cd=%0d exp 1/3", phase, cd);
    end
    for (int i = 1; i <= 180; i++) begin
      step(0, 1, 0, 0, 0, 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL countdown_vec tick=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (i == 59 || i == 60 || i == 120 || i == 179) begin
        checks++;
        if (cd !== ((i == 59) ? 2'd3 : (i == 60) ? 2'd2 : 2'd1) || phase !== 3'd1) begin
          failures++; $display("FAIL countdown_step tick=%0d cd=%0d phase=%0d", i, cd, phase);
        end
      end
    end
    checks++;
    if (phase !== 3'd2 || fe !== 1'b1 || cd !== 2'd0) begin
      failures++; $display("FAIL fight_entry phase=%0d fe=%0b cd=%0d exp 2/1/0", phase, fe, cd);
    end
  endtask

  task automatic test_touch_freeze();
    // Coincident tick must be discarded.
    step(0, 1, 1, 1, 0, 0);
    checks++;
    if (oh !== 3'd2 || ph !== 3'd3 || touch !== 1'b1 || phase !== 3'd3 || fe !== 1'b0) begin
      failures++; $display("FAIL touch oh=%0d ph=%0d touch=%0b phase=%0d fe=%0b exp 2/3/1/3/0",
                           oh, ph, touch, phase, fe);
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (touch !== 1'b0) begin
      failures++; $display("FAIL touch_pulse got=%0b exp=0", touch);
    end
    run_ticks(89);
    checks++;
    if (phase !== 3'd3) begin
      failures++; $display("FAIL freeze_hold phase=%0d exp=3", phase);
    end
    step(0, 1, 0, 0, 0, 0);
    checks++;
    if (phase !== 3'd1 || cd !== 2'd3 || dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL freeze_exit phase=%0d cd=%0d exp 1/3", phase, cd);
    end
  endtask

  task automatic test_ignored();
    run_ticks(180);
    step(0, 0, 0, 1, 1, 0);
    checks++;
    if (ph !== 3'd3 || oh !== 3'd2 || touch !== 1'b0 || phase !== 3'd2) begin
      failures++; $display("FAIL unqualified ph=%0d oh=%0d touch=%0b phase=%0d", ph, oh, touch, phase);
    end
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    checks++;
    if (ph !== 3'd3 || oh !== 3'd1 || touch !== 1'b0 || phase !== 3'd3) begin
      failures++; $display("FAIL freeze_touch ph=%0d oh=%0d touch=%0b phase=%0d exp 3/1/0/3",
                           ph, oh, touch, phase);
    end
  endtask

  task automatic test_double_touch();
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    run_ticks(180);
    step(0, 0, 1, 1, 1, 0);
    run_ticks(90 + 180);
    step(0, 0, 1, 1, 1, 0);
    checks++;
    if (ph !== 3'd1 || oh !== 3'd1 || phase !== 3'd3) begin
      failures++; $display("FAIL double_mid hp=%0d/%0d phase=%0d exp 1/1/3", ph, oh, phase);
    end
    run_ticks(90 + 180);
    step(0, 0, 1, 1, 1, 0);
    checks++;
    if (ph !== 3'd0 || oh !== 3'd0 || win !== 2'd3 || phase !== 3'd4 || touch !== 1'b1) begin
      failures++; $display("FAIL double_end hp=%0d/%0d win=%0d phase=%0d touch=%0b",
                           ph, oh, win, phase, touch);
    end
    step(0, 0, 1, 1, 0, 0);
    checks++;
    if (ph !== 3'd0 || oh !== 3'd0 || win !== 2'd3 || touch !== 1'b0 || phase !== 3'd4) begin
      failures++; $display("FAIL game_over_hold hp=%0d/%0d win=%0d touch=%0b", ph, oh, win, touch);
    end
  endtask

  task automatic test_restart();
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (ph !== 3'd3 || oh !== 3'd3 || win !== 2'd0 || phase !== 3'd1 || cd !== 2'd3) begin
      failures++; $display("FAIL restart hp=%0d/%0d win=%0d phase=%0d cd=%0d", ph, oh, win, phase, cd);
    end
  endtask

  task automatic test_reset_start();
    run_ticks(70);
    step(1, 1, 0, 0, 0, 1);
    checks++;
    if (phase !== 3'd0 || ph !== 3'd3 || oh !== 3'd3 || cd !== 2'd0 || dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_start phase=%0d hp=%0d/%0d cd=%0d exp 0/3/3/0", phase, ph, oh, cd);
    end
  endtask

  task automatic test_random();
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8000; i++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 1999) == 0));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_touch_freeze();
    test_ignored();
    test_double_touch();
    test_restart();
    test_reset_start();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
